// File: rtl/pcs_pkg.sv
// -----------------------------------------------------------------------------
// pcs_pkg
// Shared PCS constants and helpers for the 64b/66b TX/RX gearbox path.
//   SYNC_DATA / SYNC_CTRL          : 2-bit sync header encodings
//   GEARBOX_BLOCKS_PER_PERIOD      : 66b blocks per gearbox period
//   SEQ_W                          : width of the gearbox sequence counter
//   beat_e                         : position of an input beat within a block
//   pause_len(width)/cycle_len(width): period geometry for a given word width
// -----------------------------------------------------------------------------
package pcs_pkg;

  localparam logic [1:0]  SYNC_DATA                 = 2'b10;
  localparam logic [1:0]  SYNC_CTRL                 = 2'b01;
  localparam int unsigned GEARBOX_BLOCKS_PER_PERIOD = 32;
  localparam int unsigned SEQ_W                     = 7;

  typedef enum logic {
    BEAT_HDR  = 1'b0,
    BEAT_BODY = 1'b1
  } beat_e;

  // Paused cycles per period: one per input beat of a block.
  function automatic int unsigned pause_len(input int unsigned width);
    return 64 / width;
  endfunction

  // 32 blocks of 66 bits fill exactly 33 blocks' worth of output words.
  function automatic int unsigned cycle_len(input int unsigned width);
    return (GEARBOX_BLOCKS_PER_PERIOD + 1) * pause_len(width);
  endfunction

endpackage

// File: rtl/pcs_gearbox_seq.sv
// -----------------------------------------------------------------------------
// pcs_gearbox_seq
// Gearbox period counter and pause decode, shared by the TX gearbox and the
// RX slip logic.
//   i_clk      : clock
//   i_reset_n  : asynchronous active-low reset
//   o_count    : cycle counter, 0..CYCLE_LEN-1, wraps
//   o_pause    : high on the last PAUSE_LEN counts of the period
// -----------------------------------------------------------------------------
module pcs_gearbox_seq
  import pcs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  output logic [SEQ_W-1:0] o_count,
  output logic             o_pause
);

  localparam int unsigned      CYCLE_LEN   = cycle_len(DATA_WIDTH);
  localparam int unsigned      PAUSE_LEN   = pause_len(DATA_WIDTH);
  localparam logic [SEQ_W-1:0] LAST_COUNT  = SEQ_W'(CYCLE_LEN - 1);
  localparam logic [SEQ_W-1:0] PAUSE_START = SEQ_W'(CYCLE_LEN - PAUSE_LEN);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_count <= '0;
    end else if (o_count == LAST_COUNT) begin
      o_count <= '0;
    end else begin
      o_count <= o_count + 1'b1;
    end
  end

  always_comb begin
    o_pause = (o_count >= PAUSE_START);
  end

endmodule

// File: rtl/pcs_tx_gearbox.sv
// -----------------------------------------------------------------------------
// pcs_tx_gearbox
// Internal 66b -> DATA_WIDTH TX gearbox. Packs scrambled 64b/66b blocks into a
// gap-free DATA_WIDTH-bit stream and throttles upstream with o_pause.
//   i_clk      : TX user clock
//   i_reset_n  : asynchronous active-low reset
//   i_data     : block payload beat, LSB first in time
//   i_header   : sync header, used only on the first beat of a block
//   o_pause    : upstream must hold; inputs ignored this cycle
//   o_data     : registered output word, bit 0 transmitted first
//   o_valid    : high once the first accepted beat has reached o_data
//   o_sequence : gearbox cycle counter (only with PCS_TX_GEARBOX_SEQ_OUT_EN)
// DATA_WIDTH must be 32 or 64.
// Optional: define PCS_TX_GEARBOX_SEQ_OUT_EN to expose o_sequence.
// -----------------------------------------------------------------------------
module pcs_tx_gearbox
  import pcs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [1:0]            i_header,
  output logic                  o_pause,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid
`ifdef PCS_TX_GEARBOX_SEQ_OUT_EN
  ,
  output logic [SEQ_W-1:0]      o_sequence
`endif
);

  localparam int unsigned BEATS_PER_BLOCK = 64 / DATA_WIDTH;
  localparam int unsigned APP_W  = DATA_WIDTH + 2;
  localparam int unsigned BUF_W  = 2 * DATA_WIDTH + 2;
  localparam int unsigned COMB_W = DATA_WIDTH + BUF_W;
  localparam int unsigned FILL_W = (DATA_WIDTH == 64) ? 8 : 7;

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("pcs_tx_gearbox: DATA_WIDTH must be 32 or 64");
  end

  logic [SEQ_W-1:0]  seq_count;
  logic              pause;
  beat_e             beat_q;
  logic [BUF_W-1:0]  buf_q;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_sum;
  logic [FILL_W-1:0] app_len;
  logic [APP_W-1:0]  app_bits;
  logic [COMB_W-1:0] comb;

  pcs_gearbox_seq #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_seq (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .o_count   (seq_count),
    .o_pause   (pause)
  );

  always_comb begin
    o_pause = pause;
  end

`ifdef PCS_TX_GEARBOX_SEQ_OUT_EN
  always_comb begin
    o_sequence = seq_count;
  end
`endif

  // New bits land directly above the residue; bits above fill are always 0,
  // so OR-ing is a concatenation.
  always_comb begin
    app_bits = '0;
    app_len  = '0;
    if (!pause) begin
      if (beat_q == BEAT_HDR) begin
        app_bits = {i_data, i_header};
        app_len  = FILL_W'(APP_W);
      end else begin
        app_bits = {2'b00, i_data};
        app_len  = FILL_W'(DATA_WIDTH);
      end
    end
    comb     = COMB_W'(buf_q) | (COMB_W'(app_bits) << fill_q);
    fill_sum = fill_q + app_len;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
      buf_q   <= '0;
      fill_q  <= '0;
      beat_q  <= BEAT_HDR;
    end else begin
      o_data <= comb[DATA_WIDTH-1:0];
      buf_q  <= comb[COMB_W-1:DATA_WIDTH];
      fill_q <= fill_sum - FILL_W'(DATA_WIDTH);
      if (!pause) begin
        o_valid <= 1'b1;
        if (BEATS_PER_BLOCK == 2) begin
          beat_q <= (beat_q == BEAT_HDR) ? BEAT_BODY : BEAT_HDR;
        end
      end
    end
  end

  // A full output word must always be available before the shift.
  a_no_underflow : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    fill_sum >= FILL_W'(DATA_WIDTH));

  // Pauses are block-aligned, so the body beat always falls on an odd count.
  a_beat_aligned : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !pause |-> ((beat_q == BEAT_BODY) == ((BEATS_PER_BLOCK == 2) && (seq_count % 2 == 1))));

endmodule
